// File: rtl/mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_ctrl_pkg
//   Shared definitions for the memory-stage controller: the access FSM state
//   encoding, the default access timeout, widths, and a small decode helper.
// -----------------------------------------------------------------------------
package mem_ctrl_pkg;

    // Access sequencing states.
    //   IDLE : waiting for a load/store in the EX/MEM buffer
    //   REQ  : request held on the memory bus until ack or timeout
    //   DONE : one-cycle completion slot, buffer allowed to advance
    //   ERR  : one-cycle abandon slot after a timeout
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_e;

    // Maximum REQ cycles without an ack; legal range 1..255.
    localparam int unsigned TIMEOUT_DEF = 15;

    // Timeout counter width; large enough for any legal TIMEOUT.
    localparam int CNT_W = 8;

    // Default data/address width.
    localparam int unsigned DATA_W_DEF = 32;

    // A buffer entry needs the memory when it is a load or a store.
    function automatic logic needs_access(input logic is_read, input logic is_write);
        return is_read | is_write;
    endfunction

endpackage : mem_ctrl_pkg

// File: rtl/mem_access_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl_if
//   Request/acknowledge bus between the memory-stage controller and the data
//   memory. Signal names keep the controller's point of view (_o driven by the
//   controller, _i driven by the memory).
//
//   memReq_o   : request, held high for the whole access
//   memWe_o    : 1 = write, 0 = read; valid with memReq_o
//   memAddr_o  : access address, stable while memReq_o is high
//   memWdata_o : store data, stable while memReq_o is high
//   memAck_i   : single-cycle completion pulse from the memory
//   memRdata_i : read data, valid with memAck_i
//
//   Modports: master = controller side, slave = memory side.
// -----------------------------------------------------------------------------
interface mem_access_ctrl_if #(
    parameter int unsigned DATA_W = 32
) ();

    logic              memReq_o;
    logic              memWe_o;
    logic [DATA_W-1:0] memAddr_o;
    logic [DATA_W-1:0] memWdata_o;
    logic              memAck_i;
    logic [DATA_W-1:0] memRdata_i;

    modport master (
        output memReq_o,
        output memWe_o,
        output memAddr_o,
        output memWdata_o,
        input  memAck_i,
        input  memRdata_i
    );

    modport slave (
        input  memReq_o,
        input  memWe_o,
        input  memAddr_o,
        input  memWdata_o,
        output memAck_i,
        output memRdata_i
    );

endinterface : mem_access_ctrl_if

// File: rtl/mem_timeout_ctr.sv
// -----------------------------------------------------------------------------
// mem_timeout_ctr
//   Counts cycles spent waiting for a memory ack and flags the cycle on which
//   the count reaches TIMEOUT.
//
//   clk_i     : rising-edge clock
//   rst_ni    : asynchronous active-low reset
//   clear_i   : restart the count at zero (new access starting)
//   enable_i  : one more cycle without an ack
//   expired_o : combinational; high on the enabled cycle whose increment
//               brings the count to TIMEOUT, so the request line is high for
//               exactly TIMEOUT cycles before the controller gives up
// -----------------------------------------------------------------------------
module mem_timeout_ctr
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    // Count value held during the last permitted waiting cycle.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the values present before the edge, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count <= '0;
        end else if (clear_i) begin
            r_count <= '0;
        end else if (enable_i) begin
            // After expiry the controller leaves REQ, so the count simply
            // parks at TIMEOUT until the next access clears it.
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign expired_o = enable_i && (r_count == LAST_CNT);

endmodule : mem_timeout_ctr

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//   Memory-stage controller behind the EX/MEM pipeline buffer. Turns the
//   buffered load/store into one request/ack transaction, stalls the pipeline
//   until it completes, abandons it after TIMEOUT cycles without an ack, and
//   resolves taken branches into a PC redirect plus flush.
//
//   clk_i        : rising-edge clock
//   rst_ni       : asynchronous active-low reset
//   memToRead_i  : load pending in EX/MEM buffer
//   memToWrite_i : store pending in EX/MEM buffer (wins over a load)
//   branch_i     : branch in EX/MEM buffer
//   zf_i         : ALU zero flag for that instruction
//   branchAddr_i : branch target
//   aluResult_i  : effective memory address
//   rtData_i     : store data
//   mem_bus      : request/ack bus to the data memory (master side)
//   stall_o      : hold PC and all pipeline buffers (combinational)
//   readData_o   : captured load data (registered)
//   readValid_o  : one-cycle pulse, readData_o valid
//   pcSrc_o      : taken branch, select branchAddr_i (combinational)
//   pcTarget_o   : equals branchAddr_i
//   flush_o      : flush IF/ID and ID/EX, equals pcSrc_o
//   memErr_o     : sticky timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    input  logic              memToRead_i,
    input  logic              memToWrite_i,
    input  logic              branch_i,
    input  logic              zf_i,
    input  logic [DATA_W-1:0] branchAddr_i,
    input  logic [DATA_W-1:0] aluResult_i,
    input  logic [DATA_W-1:0] rtData_i,

    mem_access_ctrl_if.master mem_bus,

    output logic              stall_o,
    output logic [DATA_W-1:0] readData_o,
    output logic              readValid_o,
    output logic              pcSrc_o,
    output logic [DATA_W-1:0] pcTarget_o,
    output logic              flush_o,
    output logic              memErr_o
);

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_e            r_state;
    state_e            w_state_nxt;

    logic              r_mem_req;
    logic              r_mem_we;
    logic [DATA_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_read_data;
    logic              r_read_valid;
    logic              r_mem_err;

    logic              w_access;
    logic              w_issue;
    logic              w_ack;
    logic              w_ctr_clear;
    logic              w_ctr_enable;
    logic              w_expired;
    logic              w_stall;

    assign w_access = needs_access(memToRead_i, memToWrite_i);
    // An ack only means something while a request is on the bus.
    assign w_ack    = (r_state == REQ) && mem_bus.memAck_i;
    // A new access is only ever launched from IDLE; DONE and ERR let the
    // buffer advance first, so the same entry is never issued twice.
    assign w_issue  = (r_state == IDLE) && w_access;

    // ------------------------------------------------------------------
    // Timeout counter
    // ------------------------------------------------------------------
    assign w_ctr_clear  = w_issue;
    assign w_ctr_enable = (r_state == REQ) && !mem_bus.memAck_i;

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (w_ctr_clear),
        .enable_i  (w_ctr_enable),
        .expired_o (w_expired)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and combinational outputs
    // ------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (w_access) begin
                    w_stall     = 1'b1;
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                w_stall = 1'b1;
                // Ack has priority, so an ack on the expiring cycle is a
                // success rather than a timeout.
                if (w_ack) begin
                    w_state_nxt = DONE;
                end else if (w_expired) begin
                    w_state_nxt = ERR;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            ERR: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request bus, captured data and error flag
    // ------------------------------------------------------------------
    // These are plain control/data registers, so all of them are reset;
    // an access abandoned by reset leaves no trace on the outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_read_data  <= '0;
            r_read_valid <= 1'b0;
            r_mem_err    <= 1'b0;
        end else begin
            // Request follows the state register exactly, but is its own
            // flop so the bus sees a clean registered level.
            r_mem_req    <= (w_state_nxt == REQ);
            // Pulses in the DONE cycle, and only for loads.
            r_read_valid <= w_ack && !r_mem_we;

            if (w_issue) begin
                r_mem_addr  <= aluResult_i;
                r_mem_wdata <= rtData_i;
                r_mem_we    <= memToWrite_i;
            end

            if (w_ack && !r_mem_we) begin
                r_read_data <= mem_bus.memRdata_i;
            end

            if (w_expired) begin
                r_mem_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mem_bus.memReq_o   = r_mem_req;
    assign mem_bus.memWe_o    = r_mem_we;
    assign mem_bus.memAddr_o  = r_mem_addr;
    assign mem_bus.memWdata_o = r_mem_wdata;

    assign stall_o     = w_stall;
    assign readData_o  = r_read_data;
    assign readValid_o = r_read_valid;
    assign memErr_o    = r_mem_err;

    // A branch cannot redirect while the pipeline is frozen: the buffer
    // entry has not been accepted yet and will be seen again.
    assign pcSrc_o    = branch_i && zf_i && !w_stall;
    assign flush_o    = pcSrc_o;
    assign pcTarget_o = branchAddr_i;

endmodule : mem_access_ctrl

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
//   Directed bench for mem_access_ctrl: a per-cycle vector table for the
//   load / branch / spurious-ack behaviour, followed by hand-written
//   sequences for the delayed store, ack-at-timeout boundary, back-to-back
//   accesses, timeout, and reset in the middle of a request.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

    localparam int unsigned TB_TIMEOUT = 15;
    localparam int unsigned TB_DW      = 32;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              memToRead_i;
    logic              memToWrite_i;
    logic              branch_i;
    logic              zf_i;
    logic [TB_DW-1:0]  branchAddr_i;
    logic [TB_DW-1:0]  aluResult_i;
    logic [TB_DW-1:0]  rtData_i;
    logic              stall_o;
    logic [TB_DW-1:0]  readData_o;
    logic              readValid_o;
    logic              pcSrc_o;
    logic [TB_DW-1:0]  pcTarget_o;
    logic              flush_o;
    logic              memErr_o;

    mem_access_ctrl_if #(.DATA_W(TB_DW)) mem_bus ();

    mem_access_ctrl #(
        .TIMEOUT (TB_TIMEOUT),
        .DATA_W  (TB_DW)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .memToRead_i  (memToRead_i),
        .memToWrite_i (memToWrite_i),
        .branch_i     (branch_i),
        .zf_i         (zf_i),
        .branchAddr_i (branchAddr_i),
        .aluResult_i  (aluResult_i),
        .rtData_i     (rtData_i),
        .mem_bus      (mem_bus),
        .stall_o      (stall_o),
        .readData_o   (readData_o),
        .readValid_o  (readValid_o),
        .pcSrc_o      (pcSrc_o),
        .pcTarget_o   (pcTarget_o),
        .flush_o      (flush_o),
        .memErr_o     (memErr_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // on the falling edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    typedef struct {
        string       name;
        logic        rd, wr, br, zf, ack;
        logic [31:0] addr, wdata, rdata_in, baddr;
        logic        e_stall, e_req, e_we, e_rvalid, e_pcsrc, e_err;
        logic [31:0] e_maddr, e_rdata;
    } vec_t;

    localparam int N_VEC = 13;
    vec_t vecs [N_VEC];

    task automatic apply(input vec_t v);
        memToRead_i        = v.rd;
        memToWrite_i       = v.wr;
        branch_i           = v.br;
        zf_i               = v.zf;
        mem_bus.memAck_i   = v.ack;
        aluResult_i        = v.addr;
        rtData_i           = v.wdata;
        mem_bus.memRdata_i = v.rdata_in;
        branchAddr_i       = v.baddr;
    endtask

    task automatic clear_inputs();
        memToRead_i        = 1'b0;
        memToWrite_i       = 1'b0;
        branch_i           = 1'b0;
        zf_i               = 1'b0;
        mem_bus.memAck_i   = 1'b0;
        aluResult_i        = '0;
        rtData_i           = '0;
        mem_bus.memRdata_i = '0;
        branchAddr_i       = '0;
    endtask

    // Safety net: the sequences below are all bounded, this only fires if
    // something in the simulation itself stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
        $fatal(1);
    end

    initial begin
        int n_stall;
        int n_high;
        int n_req;
        int n_rv;
        int idx;
        logic prev_req;
        logic done;

        //                 name          rd wr br zf ak addr   wdata rdata_in      baddr   st rq we rv pc er maddr  rdata
        vecs[0]  = '{"idle",             0, 0, 0, 0, 0, 32'h0,  32'h0, 32'h0,        32'h0,   0, 0, 0, 0, 0, 0, 32'h0,  32'h0};
        vecs[1]  = '{"ld_issue",         1, 0, 0, 0, 0, 32'h40, 32'h0, 32'h0,        32'h0,   1, 0, 0, 0, 0, 0, 32'h0,  32'h0};
        vecs[2]  = '{"ld_req",           1, 0, 0, 0, 1, 32'h40, 32'h0, 32'hDEADBEEF, 32'h0,   1, 1, 0, 0, 0, 0, 32'h40, 32'h0};
        vecs[3]  = '{"ld_done",          1, 0, 0, 0, 0, 32'h40, 32'h0, 32'h0,        32'h0,   0, 0, 0, 1, 0, 0, 32'h40, 32'hDEADBEEF};
        vecs[4]  = '{"after_ld",         0, 0, 0, 0, 0, 32'h0,  32'h0, 32'h0,        32'h0,   0, 0, 0, 0, 0, 0, 32'h40, 32'hDEADBEEF};
        vecs[5]  = '{"br_taken",         0, 0, 1, 1, 0, 32'h0,  32'h0, 32'h0,        32'h200, 0, 0, 0, 0, 1, 0, 32'h40, 32'hDEADBEEF};
        vecs[6]  = '{"br_not_taken",     0, 0, 1, 0, 0, 32'h0,  32'h0, 32'h0,        32'h200, 0, 0, 0, 0, 0, 0, 32'h40, 32'hDEADBEEF};
        vecs[7]  = '{"ack_in_idle",      0, 0, 0, 0, 1, 32'h0,  32'h0, 32'h11111111, 32'h0,   0, 0, 0, 0, 0, 0, 32'h40, 32'hDEADBEEF};
        vecs[8]  = '{"after_spur_ack",   0, 0, 0, 0, 0, 32'h0,  32'h0, 32'h0,        32'h0,   0, 0, 0, 0, 0, 0, 32'h40, 32'hDEADBEEF};
        vecs[9]  = '{"ld_br_issue",      1, 0, 1, 1, 0, 32'h80, 32'h0, 32'h0,        32'h300, 1, 0, 0, 0, 0, 0, 32'h40, 32'hDEADBEEF};
        vecs[10] = '{"ld_br_req",        1, 0, 1, 1, 1, 32'h80, 32'h0, 32'h0BADF00D, 32'h300, 1, 1, 0, 0, 0, 0, 32'h80, 32'hDEADBEEF};
        vecs[11] = '{"ld_br_done",       1, 0, 1, 1, 0, 32'h80, 32'h0, 32'h0,        32'h300, 0, 0, 0, 1, 1, 0, 32'h80, 32'h0BADF00D};
        vecs[12] = '{"quiet",            0, 0, 0, 0, 0, 32'h0,  32'h0, 32'h0,        32'h0,   0, 0, 0, 0, 0, 0, 32'h80, 32'h0BADF00D};

        // ---------------- reset values ----------------
        rst_ni = 1'b0;
        clear_inputs();
        #3;
        check("rst_state_stall", stall_o,            0);
        check("rst_req",         mem_bus.memReq_o,   0);
        check("rst_we",          mem_bus.memWe_o,    0);
        check("rst_addr",        mem_bus.memAddr_o,  0);
        check("rst_wdata",       mem_bus.memWdata_o, 0);
        check("rst_rdata",       readData_o,         0);
        check("rst_rvalid",      readValid_o,        0);
        check("rst_err",         memErr_o,           0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();

        // ---------------- vector table ----------------
        for (int i = 0; i < N_VEC; i++) begin
            apply(vecs[i]);
            @(negedge clk_i);
            check({vecs[i].name, "/stall"},  stall_o,           vecs[i].e_stall);
            check({vecs[i].name, "/req"},    mem_bus.memReq_o,  vecs[i].e_req);
            check({vecs[i].name, "/we"},     mem_bus.memWe_o,   vecs[i].e_we);
            check({vecs[i].name, "/rvalid"}, readValid_o,       vecs[i].e_rvalid);
            check({vecs[i].name, "/pcsrc"},  pcSrc_o,           vecs[i].e_pcsrc);
            check({vecs[i].name, "/flush"},  flush_o,           vecs[i].e_pcsrc);
            check({vecs[i].name, "/target"}, pcTarget_o,        vecs[i].baddr);
            check({vecs[i].name, "/err"},    memErr_o,          vecs[i].e_err);
            check({vecs[i].name, "/maddr"},  mem_bus.memAddr_o, vecs[i].e_maddr);
            check({vecs[i].name, "/rdata"},  readData_o,        vecs[i].e_rdata);
            tick();
        end

        // ---------------- store, ack on 4th REQ cycle ----------------
        clear_inputs();
        memToWrite_i = 1'b1;
        aluResult_i  = 32'h10;
        rtData_i     = 32'h1234;
        n_stall      = 0;
        @(negedge clk_i);
        check("st_issue_stall", stall_o,          1);
        check("st_issue_req",   mem_bus.memReq_o, 0);
        if (stall_o) n_stall++;
        for (int i = 1; i <= 4; i++) begin
            tick();
            mem_bus.memAck_i = (i == 4);
            @(negedge clk_i);
            check($sformatf("st_req%0d_req", i),   mem_bus.memReq_o,   1);
            check($sformatf("st_req%0d_we", i),    mem_bus.memWe_o,    1);
            check($sformatf("st_req%0d_addr", i),  mem_bus.memAddr_o,  32'h10);
            check($sformatf("st_req%0d_wdata", i), mem_bus.memWdata_o, 32'h1234);
            if (stall_o) n_stall++;
        end
        tick();
        mem_bus.memAck_i = 1'b0;
        @(negedge clk_i);
        check("st_done_stall",  stall_o,          0);
        check("st_done_req",    mem_bus.memReq_o, 0);
        check("st_done_rvalid", readValid_o,      0);
        check("st_done_rdata",  readData_o,       32'h0BADF00D);
        check("st_stall_cycles", n_stall,         5);
        tick();
        clear_inputs();

        // ---------------- ack on the expiring REQ cycle ----------------
        memToRead_i        = 1'b1;
        aluResult_i        = 32'h44;
        mem_bus.memRdata_i = 32'hCAFE0001;
        @(negedge clk_i);
        for (int i = 1; i <= int'(TB_TIMEOUT); i++) begin
            tick();
            mem_bus.memAck_i = (i == int'(TB_TIMEOUT));
            @(negedge clk_i);
            check($sformatf("edge_req%0d", i), mem_bus.memReq_o, 1);
        end
        tick();
        mem_bus.memAck_i = 1'b0;
        @(negedge clk_i);
        check("edge_done_stall",  stall_o,     0);
        check("edge_done_rvalid", readValid_o, 1);
        check("edge_done_err",    memErr_o,    0);
        check("edge_done_rdata",  readData_o,  32'hCAFE0001);
        tick();
        clear_inputs();

        // ---------------- back-to-back load then store ----------------
        n_req    = 0;
        n_rv     = 0;
        idx      = 0;
        prev_req = 1'b0;
        mem_bus.memRdata_i = 32'h5A5A5A5A;
        for (int cyc = 0; cyc < 12; cyc++) begin
            memToRead_i      = (idx == 0);
            memToWrite_i     = (idx == 1);
            aluResult_i      = (idx == 0) ? 32'h100 : 32'h104;
            rtData_i         = (idx == 1) ? 32'h77  : 32'h0;
            // Zero-wait memory: ack every cycle the request is up.
            mem_bus.memAck_i = mem_bus.memReq_o;
            @(negedge clk_i);
            if (mem_bus.memReq_o && !prev_req) n_req++;
            prev_req = mem_bus.memReq_o;
            if (readValid_o) n_rv++;
            if (!stall_o && idx < 2) idx++;
            tick();
        end
        check("b2b_requests", n_req,              2);
        check("b2b_rvalids",  n_rv,               1);
        check("b2b_retired",  idx,                2);
        check("b2b_addr",     mem_bus.memAddr_o,  32'h104);
        check("b2b_wdata",    mem_bus.memWdata_o, 32'h77);
        check("b2b_we",       mem_bus.memWe_o,    1);
        check("b2b_rdata",    readData_o,         32'h5A5A5A5A);
        clear_inputs();

        // ---------------- timeout ----------------
        memToRead_i = 1'b1;
        aluResult_i = 32'h55;
        @(negedge clk_i);
        check("to_issue_stall", stall_o, 1);
        n_high = 0;
        done   = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            tick();
            @(negedge clk_i);
            if (mem_bus.memReq_o) begin
                n_high++;
            end else if (!stall_o) begin
                done = 1'b1;
                check("to_err_rvalid", readValid_o, 0);
                check("to_err_flag",   memErr_o,    1);
                check("to_err_rdata",  readData_o,  32'h5A5A5A5A);
            end
        end
        check("to_reached_err", done,   1);
        check("to_req_cycles",  n_high, TB_TIMEOUT);
        tick();
        memToRead_i = 1'b0;
        @(negedge clk_i);
        check("to_idle_stall", stall_o,          0);
        check("to_idle_req",   mem_bus.memReq_o, 0);
        check("to_idle_err",   memErr_o,         1);
        tick();
        @(negedge clk_i);
        check("to_err_sticky", memErr_o, 1);
        tick();

        // ---------------- reset in the middle of REQ ----------------
        memToRead_i = 1'b1;
        aluResult_i = 32'h60;
        @(negedge clk_i);
        tick();
        @(negedge clk_i);
        check("rq_in_req", mem_bus.memReq_o, 1);
        #2;
        rst_ni      = 1'b0;
        memToRead_i = 1'b0;
        #1;
        check("rq_rst_req",    mem_bus.memReq_o,  0);
        check("rq_rst_stall",  stall_o,           0);
        check("rq_rst_err",    memErr_o,          0);
        check("rq_rst_rdata",  readData_o,        0);
        check("rq_rst_addr",   mem_bus.memAddr_o, 0);
        check("rq_rst_rvalid", readValid_o,       0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        mem_bus.memAck_i   = 1'b1;
        mem_bus.memRdata_i = 32'hFFFF0000;
        @(negedge clk_i);
        check("rq_spur_req",   mem_bus.memReq_o, 0);
        check("rq_spur_stall", stall_o,          0);
        tick();
        mem_bus.memAck_i = 1'b0;
        @(negedge clk_i);
        check("rq_post_rvalid", readValid_o,      0);
        check("rq_post_req",    mem_bus.memReq_o, 0);
        check("rq_post_rdata",  readData_o,       0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_mem_access_ctrl
